exe2mem_skid_reg: RTL
=====================

Name: exe2mem_skid_reg

Overview:
- Elastic EXE→MEM pipeline register sitting directly downstream of the ALU.
- Captures the ALU result, store data, destination register and MEM/WB control bits of one instruction per transfer.
- A 2-entry skid buffer lets a multi-cycle data memory stall the MEM stage while EXE's ready stays registered; no combinational ready path back into EXE.
- Also exposes the buffered destinations to the forwarding unit.

Parameters:
- WORD_LEN, 32, width of ALU result and store data
- REG_FILE_ADDR_LEN, 5, width of destination register index

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  EXE stage presents an instruction
- in_ready  out  1  block accepts this cycle; registered output
- ALU_result  in  WORD_LEN  ALU output of the EXE instruction
- ST_value  in  WORD_LEN  store data (rt value after forwarding)
- dest  in  REG_FILE_ADDR_LEN  destination register index
- WB_EN  in  1  instruction writes the register file
- MEM_R_EN  in  1  load
- MEM_W_EN  in  1  store
- out_valid  out  1  head entry valid toward MEM
- out_ready  in  1  MEM stage accepts head this cycle
- out_ALU_result  out  WORD_LEN  head payload
- out_ST_value  out  WORD_LEN  head payload
- out_dest  out  REG_FILE_ADDR_LEN  head payload
- out_WB_EN  out  1  head payload, gated by out_valid
- out_MEM_R_EN  out  1  head payload, gated by out_valid
- out_MEM_W_EN  out  1  head payload, gated by out_valid
- fwd_skid_dest  out  REG_FILE_ADDR_LEN  skid-entry destination for the forwarding unit
- fwd_skid_WB_EN  out  1  skid-entry WB_EN, gated by skid valid
- occupancy  out  2  number of buffered entries (0, 1, 2)

Behaviour:
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Payload bits are sampled only on in_fire.
- States: EMPTY (occupancy 0), HEAD (1, head register valid), FULL (2, head and skid valid). The skid entry is always younger than the head.
- EMPTY:
  - in_fire → HEAD; head ← input.
- HEAD:
  - in_fire & out_fire → HEAD; head ← input.
  - in_fire only → FULL; skid ← input.
  - out_fire only → EMPTY.
  - Neither → hold.
- FULL:
  - out_fire → HEAD; head ← skid.
  - in_fire is impossible because in_ready = 0.
- in_ready:
  - Registered; equals (next_state != FULL).
  - Deasserts the cycle after the buffer becomes full.
  - Reasserts the cycle after the head drains from FULL.
- out_valid = (state != EMPTY), driven from a register.
- Latency: an instruction accepted into EMPTY appears on out_* the next cycle. Throughput is 1 per cycle while out_ready = 1.
- Order is strictly FIFO; no instruction is dropped or duplicated.
- Gating:
  - out_WB_EN, out_MEM_R_EN and out_MEM_W_EN are forced to 0 whenever out_valid = 0, so bubbles never write.
  - Data payload outputs hold their last value when invalid.
  - fwd_skid_WB_EN is 0 unless state == FULL.
- out_ready may be asserted while out_valid = 0; it is then ignored and causes no state change.
- in_valid with all-zero control bits (e.g. a NOP) is still a real transfer and occupies a slot.
- Reset, asserted asynchronously at any time including mid-stall:
  - State and outputs: state EMPTY, out_valid 0, in_ready 1, occupancy 0.
  - All payload registers: 0.
  - Buffered instructions are discarded.
- First edge after reset release behaves as EMPTY.

Decomposition:
- Shared defines: WORD_LEN, REG_FILE_ADDR_LEN, and a 2-bit state encoding (STATE_EMPTY = 0, STATE_HEAD = 1, STATE_FULL = 2).
- Payload concatenation width: 2*WORD_LEN + REG_FILE_ADDR_LEN + 3.
- One natural sub-module, payload_reg: a WORD-agnostic load-enabled register with async reset, parameterised by width, instantiated twice (head, skid).
- The FSM and ready logic stay in the top module.

Test Plan:
- Reset with out_ready = 1: rst pulse mid-simulation → out_valid 0, in_ready 1, occupancy 0, out_ALU_result 0.
- Streaming: present ALU_result 5, 6, 7 on consecutive cycles with out_ready = 1 → out_ALU_result 5, 6, 7 on the following consecutive cycles; occupancy stays 1; in_ready stays 1.
- Stall fill: out_ready = 0, send A (dest 3, WB_EN 1) then B (dest 4) → occupancy 2; in_ready 0 the cycle after B; head shows A; fwd_skid_dest 4 with fwd_skid_WB_EN 1; further in_valid is not accepted.
- Drain: from FULL (A, B), raise out_ready for 2 cycles → A then B emitted in order, occupancy 2→1→0, in_ready 1 one cycle after A leaves.
- Bubble gating: EMPTY state, previous head had MEM_W_EN 1 → out_MEM_W_EN 0 and out_WB_EN 0 while out_valid 0.
- Reset mid-stall: FULL with out_ready 0, assert rst → out_valid 0 immediately (async); after release, one new instruction (ALU_result 0x1234) appears alone at head, with no trace of A/B.

Source files
------------

// File: rtl/exe2mem_skid_reg_pkg.sv
// Shared widths, state encoding and payload sizing for the EXE->MEM elastic pipeline register.
package exe2mem_skid_reg_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        STATE_EMPTY = 2'd0,
        STATE_HEAD  = 2'd1,
        STATE_FULL  = 2'd2
    } state_t;

    // ALU result + store data + destination + WB_EN/MEM_R_EN/MEM_W_EN.
    function automatic int payload_width(input int word_len, input int addr_len);
        return 2 * word_len + addr_len + 3;
    endfunction

endpackage

// File: rtl/exe2mem_skid_reg_payload_reg.sv
// Load-enabled register with asynchronous active-high reset; holds one
// instruction's payload (used for both the head and the skid entry).
module payload_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    // NOTE: the data registers are reset too, so a discarded instruction
    // never lingers on the payload outputs after a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exe2mem_skid_reg.sv
// Elastic EXE->MEM pipeline register: 2-entry skid buffer with a registered
// in_ready, so MEM stalls never form a combinational path back into EXE.
module exe2mem_skid_reg #(
    parameter int WORD_LEN          = exe2mem_skid_reg_pkg::WORD_LEN,
    parameter int REG_FILE_ADDR_LEN = exe2mem_skid_reg_pkg::REG_FILE_ADDR_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_LEN-1:0]          ALU_result,
    input  logic [WORD_LEN-1:0]          ST_value,
    input  logic [REG_FILE_ADDR_LEN-1:0] dest,
    input  logic                         WB_EN,
    input  logic                         MEM_R_EN,
    input  logic                         MEM_W_EN,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_LEN-1:0]          out_ALU_result,
    output logic [WORD_LEN-1:0]          out_ST_value,
    output logic [REG_FILE_ADDR_LEN-1:0] out_dest,
    output logic                         out_WB_EN,
    output logic                         out_MEM_R_EN,
    output logic                         out_MEM_W_EN,
    output logic [REG_FILE_ADDR_LEN-1:0] fwd_skid_dest,
    output logic                         fwd_skid_WB_EN,
    output logic [1:0]                   occupancy
);

    import exe2mem_skid_reg_pkg::*;

    localparam int PW = payload_width(WORD_LEN, REG_FILE_ADDR_LEN);

    state_t          state;
    state_t          next_state;
    logic            in_fire;
    logic            out_fire;
    logic            head_load;
    logic            skid_load;
    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   head_d;
    logic [PW-1:0]   head_q;
    logic [PW-1:0]   skid_q;
    logic            head_wb_en;
    logic            head_mem_r_en;
    logic            head_mem_w_en;

    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;
    assign in_payload = {ALU_result, ST_value, dest, WB_EN, MEM_R_EN, MEM_W_EN};

    // NOTE: every output of this block is defaulted first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
        head_load  = 1'b0;
        skid_load  = 1'b0;
        case (state)
            STATE_EMPTY: begin
                if (in_fire) begin
                    next_state = STATE_HEAD;
                    head_load  = 1'b1;
                end
            end
            STATE_HEAD: begin
                if (in_fire && out_fire) begin
                    head_load = 1'b1;
                end else if (in_fire) begin
                    next_state = STATE_FULL;
                    skid_load  = 1'b1;
                end else if (out_fire) begin
                    next_state = STATE_EMPTY;
                end
            end
            STATE_FULL: begin
                // in_ready is already low here, so only the drain side can move.
                if (out_fire) begin
                    next_state = STATE_HEAD;
                    head_load  = 1'b1;
                end
            end
            default: next_state = STATE_EMPTY;
        endcase
    end

    // The skid entry is always the younger one, so it refills the head on drain.
    assign head_d = (state == STATE_FULL) ? skid_q : in_payload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STATE_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state != STATE_FULL);
            out_valid <= (next_state != STATE_EMPTY);
        end
    end

    payload_reg #(.WIDTH(PW)) u_head (
        .clk  (clk),
        .rst  (rst),
        .load (head_load),
        .d    (head_d),
        .q    (head_q)
    );

    payload_reg #(.WIDTH(PW)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load),
        .d    (in_payload),
        .q    (skid_q)
    );

    assign {out_ALU_result, out_ST_value, out_dest,
            head_wb_en, head_mem_r_en, head_mem_w_en} = head_q;

    // Control bits are masked on bubbles; data simply holds its last value.
    assign out_WB_EN    = head_wb_en    & out_valid;
    assign out_MEM_R_EN = head_mem_r_en & out_valid;
    assign out_MEM_W_EN = head_mem_w_en & out_valid;

    assign fwd_skid_dest  = skid_q[3 +: REG_FILE_ADDR_LEN];
    assign fwd_skid_WB_EN = skid_q[2] & (state == STATE_FULL);

    assign occupancy = state;

endmodule
